// File: rtl/exec_wb_skid.sv
// exec_wb_skid: two-entry registered skid buffer between the EXEC stage
// output and the WB stage input. Both handshake directions are driven from
// registers only, which cuts the EXEC-side and WB-side timing paths.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   EXEC presents a word
//   in_data    EXEC word (WIDTH bits)
//   in_ready   buffer can accept a word (registered)
//   out_valid  head word available to WB (registered)
//   out_data   head word (registered)
//   out_ready  WB consumes the head this cycle
//   flush      synchronous discard of all held words
//   occupancy  number of held words: 0, 1 or 2
//   xfer_cnt   completed output transfers, modulo 2^CNT_W
module exec_wb_skid #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_cnt
);

  // The occupancy count is itself the FSM state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q;
  logic             push, pop;

  // Handshake outputs depend on registered state only.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data  = head_q;
  assign occupancy = state_q;
  assign xfer_cnt  = cnt_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    if (flush) begin
      // Held words are dropped; data registers may keep stale contents.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          unique case ({push, pop})
            2'b10: begin
              skid_d  = in_data;
              state_d = FULL;
            end
            2'b01: state_d = EMPTY;
            // Head leaves and the new word replaces it in the same cycle.
            2'b11: head_d = in_data;
            default: ;
          endcase
        end
        FULL: begin
          // in_ready is low here, so only a pop can occur.
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      // NOTE: the data registers are reset too, because out_data must read
      // zero during reset; a plain storage array would not need this.
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      // A pop in a flush cycle still counts: WB has already taken the word.
      if (pop) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule
